clb_cfgchain: RTL and testbench

- Parametrised successor to the single four-input configurable logic block (CLB) model. It holds NUM_LE logic elements; each has a LUT_K-input LUT, one storage flop, optional flop feedback into the LUT, and synchronous set/clear.
- Configuration is loaded at runtime over a serial shift chain rather than fixed at elaboration. The chain has a load FSM and a daisy-chain pass-through, so CLB instances can be cascaded into an array.
- Logic outputs are forced to 0 until configuration completes.

---
 rtl/clb_cfgchain.sv | 239 +++++++++++++++++++++++
 tb/tb_clb_cfgchain.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/clb_cfgchain.sv
// -----------------------------------------------------------------------------
// clb_cfgchain
//
// Configurable logic block with NUM_LE logic elements. Each element has a
// LUT_K-input look-up table, one storage flop with optional feedback into the
// LUT address, and synchronous set/clear. The configuration is loaded at run
// time over a serial shift chain. A registered pass-through lets several
// blocks be daisy-chained into an array.
//
// The logic outputs are held at 0 until the block has been fully configured.
//
// Ports
//   K          in   clock, all state changes on the rising edge
//   RST        in   synchronous active-high reset, overrides everything else
//   CFG_EN     in   configuration shift / pass-through enable
//   CFG_DIN    in   serial configuration data (first bit ends up at the MSB)
//   CFG_EN_OUT out  registered enable to the downstream block
//   CFG_DOUT   out  registered data to the downstream block
//   CFG_DONE   out  high while the block is configured and running
//   IN         in   LUT inputs, element i uses IN[i*LUT_K +: LUT_K]
//   CE         in   per-element flop clock enable
//   SR         in   per-element synchronous set/reset request
//   OUT        out  per-element logic output
//
// Per-element configuration field, base b = i*W:
//   b +: 2**LUT_K  LUT contents
//   b+2**LUT_K     OUTSEL (0 = LUT output, 1 = flop)
//   +1             FBSEL  (1 = flop replaces the top LUT input)
//   +2..+3         SRMODE
//   +4             INIT   (flop value loaded when configuration completes)
// -----------------------------------------------------------------------------
module clb_cfgchain #(
  parameter int LUT_K  = 4,
  parameter int NUM_LE = 2
) (
  input  logic                      K,
  input  logic                      RST,
  input  logic                      CFG_EN,
  input  logic                      CFG_DIN,
  output logic                      CFG_EN_OUT,
  output logic                      CFG_DOUT,
  output logic                      CFG_DONE,
  input  logic [NUM_LE*LUT_K-1:0]   IN,
  input  logic [NUM_LE-1:0]         CE,
  input  logic [NUM_LE-1:0]         SR,
  output logic [NUM_LE-1:0]         OUT
);

  localparam int LUT_SZ  = 2**LUT_K;
  localparam int W       = LUT_SZ + 5;
  localparam int CFG_LEN = NUM_LE * W;
  localparam int CW      = $clog2(CFG_LEN + 1);

  // Count value on whose shift the load completes, and the saturation value.
  localparam logic [CW-1:0] LAST_CNT = CW'(CFG_LEN - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CFG_LEN);

  typedef enum logic [1:0] {
    ST_UNCFG  = 2'd0,
    ST_LOAD   = 2'd1,
    ST_INIT   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  // LUT read: selects one configuration bit by the assembled address.
  function automatic logic lut_read(input logic [LUT_SZ-1:0] lut,
                                    input logic [LUT_K-1:0]  addr);
    lut_read = lut[addr];
  endfunction

  state_e              state_q, state_d;
  logic [CFG_LEN-1:0]  cfg_q, cfg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                en_out_q, en_out_d;
  logic                dout_q, dout_d;
  logic                shift_s;
  logic                active_s;
  logic                init_s;

  // Shifting is only possible before the load has completed.
  assign shift_s  = CFG_EN && ((state_q == ST_UNCFG) || (state_q == ST_LOAD));
  assign active_s = (state_q == ST_ACTIVE);
  assign init_s   = (state_q == ST_INIT);

  // State register plus chain/counter/output registers.
  always_ff @(posedge K) begin
    if (RST) begin
      state_q  <= ST_UNCFG;
      cfg_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      en_out_q <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      en_out_q <= en_out_d;
      dout_q   <= dout_d;
    end
  end

  // Next-state logic of the load FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNCFG: begin
        if (CFG_EN) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_UNCFG;
        end
      end
      ST_LOAD: begin
        if (CFG_EN && (cnt_q == LAST_CNT)) begin
          state_d = ST_INIT;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_INIT:   state_d = ST_ACTIVE;
      ST_ACTIVE: state_d = ST_ACTIVE;
      default:   state_d = ST_UNCFG;
    endcase
  end

  // Configuration shift register and bit counter; both freeze once loaded.
  always_comb begin
    cfg_d = cfg_q;
    cnt_d = cnt_q;
    if (shift_s) begin
      cfg_d = {cfg_q[CFG_LEN-2:0], CFG_DIN};
      if (state_q == ST_UNCFG) begin
        cnt_d = CW'(1);
      end else if (cnt_q != FULL_CNT) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cfg_d = cfg_q;
      cnt_d = cnt_q;
    end
  end

  // FSM outputs: done flag and the daisy-chain pass-through, which only
  // forwards once this block is configured so downstream blocks never see
  // our own configuration stream.
  always_comb begin
    done_d = (state_d == ST_ACTIVE);
    if (active_s) begin
      en_out_d = CFG_EN;
      dout_d   = CFG_DIN;
    end else begin
      en_out_d = 1'b0;
      dout_d   = 1'b0;
    end
  end

  assign CFG_DONE   = done_q;
  assign CFG_EN_OUT = en_out_q;
  assign CFG_DOUT   = dout_q;

  // ---------------------------------------------------------------------------
  // Logic elements
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_LE; gi++) begin : g_le
    localparam int B = gi * W;

    logic [LUT_SZ-1:0] lut_s;
    logic              outsel_s;
    logic              fbsel_s;
    logic [1:0]        srmode_s;
    logic              init_val_s;
    logic [LUT_K-1:0]  in_s;
    logic [LUT_K-1:0]  addr_s;
    logic              f_s;
    logic              q_q, q_d;
    logic              out_s;

    assign lut_s      = cfg_q[B +: LUT_SZ];
    assign outsel_s   = cfg_q[B + LUT_SZ];
    assign fbsel_s    = cfg_q[B + LUT_SZ + 1];
    assign srmode_s   = cfg_q[B + LUT_SZ + 2 +: 2];
    assign init_val_s = cfg_q[B + LUT_SZ + 4];
    assign in_s       = IN[gi*LUT_K +: LUT_K];

    // With feedback enabled the flop takes the place of the top LUT input.
    assign addr_s = {(fbsel_s ? q_q : in_s[LUT_K-1]), in_s[LUT_K-2:0]};
    assign f_s    = lut_read(lut_s, addr_s);

    // Storage flop of this element.
    always_ff @(posedge K) begin
      if (RST) begin
        q_q <= 1'b0;
      end else begin
        q_q <= q_d;
      end
    end

    // Flop next value. An SRMODE=11 clear wins even over a disabled CE;
    // the other set/clear modes only act while CE is high.
    always_comb begin
      q_d = 1'b0;
      case (state_q)
        ST_INIT: q_d = init_val_s;
        ST_ACTIVE: begin
          if ((srmode_s == 2'b11) && SR[gi]) begin
            q_d = 1'b0;
          end else if (!CE[gi]) begin
            q_d = q_q;
          end else if ((srmode_s == 2'b01) && SR[gi]) begin
            q_d = 1'b1;
          end else if ((srmode_s == 2'b10) && SR[gi]) begin
            q_d = 1'b0;
          end else begin
            q_d = f_s;
          end
        end
        default: q_d = 1'b0;
      endcase
    end

    // Output mux, gated to 0 until the block is running.
    always_comb begin
      out_s = 1'b0;
      if (active_s) begin
        out_s = outsel_s ? q_q : f_s;
      end else begin
        out_s = 1'b0;
      end
    end

    assign OUT[gi] = out_s;
  end

endmodule

// File: tb/tb_clb_cfgchain.sv
// -----------------------------------------------------------------------------
// Testbench for clb_cfgchain at default parameters (LUT_K=4, NUM_LE=2,
// 42-bit chain). Each cycle the expected output vector
// {CFG_DONE, CFG_EN_OUT, CFG_DOUT, OUT[1], OUT[0]} is pushed to a scoreboard
// when the stimulus is driven, then popped and compared after the clock edge.
// -----------------------------------------------------------------------------
module tb_clb_cfgchain;

  localparam int CFG_LEN = 42;

  logic       k;
  logic       rst;
  logic       cfg_en;
  logic       cfg_din;
  logic       cfg_en_out;
  logic       cfg_dout;
  logic       cfg_done;
  logic [7:0] in_v;
  logic [1:0] ce;
  logic [1:0] sr;
  logic [1:0] out_v;

  int n_checks = 0;
  int n_errors = 0;

  string      tag_q[$];
  logic [4:0] exp_q[$];

  clb_cfgchain #(.LUT_K(4), .NUM_LE(2)) dut (
    .K          (k),
    .RST        (rst),
    .CFG_EN     (cfg_en),
    .CFG_DIN    (cfg_din),
    .CFG_EN_OUT (cfg_en_out),
    .CFG_DOUT   (cfg_dout),
    .CFG_DONE   (cfg_done),
    .IN         (in_v),
    .CE         (ce),
    .SR         (sr),
    .OUT        (out_v)
  );

  initial k = 1'b0;
  always #5 k = ~k;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Compare one observed value with its expectation.
  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", tag, got, want);
    end
  endtask

  // Push the expectation, clock once, sample on the falling edge and compare.
  task automatic step(input string tag, input logic [4:0] want);
    string      t;
    logic [4:0] e;
    tag_q.push_back(tag);
    exp_q.push_back(want);
    @(posedge k);
    @(negedge k);
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    check_eq(t, {cfg_done, cfg_en_out, cfg_dout, out_v[1], out_v[0]}, e);
  endtask

  // One logic-element field: {INIT, SRMODE, FBSEL, OUTSEL, LUT}.
  function automatic logic [20:0] make_le(input logic [15:0] lut, input logic outsel,
                                          input logic fbsel, input logic [1:0] srmode,
                                          input logic init);
    make_le = {init, srmode, fbsel, outsel, lut};
  endfunction

  // Send chain bits n = first .. first+count-1 (bit n is cfg[41-n]).
  task automatic send_bits(input logic [CFG_LEN-1:0] cfg, input int first, input int count);
    for (int n = first; n < first + count; n++) begin
      cfg_en  = 1'b1;
      cfg_din = cfg[CFG_LEN-1-n];
      step("load", 5'b00000);
    end
    cfg_en  = 1'b0;
    cfg_din = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step("reset", 5'b00000);
    rst = 1'b0;
  endtask

  task automatic load_full(input logic [CFG_LEN-1:0] cfg);
    do_reset();
    send_bits(cfg, 0, CFG_LEN);
  endtask

  logic [CFG_LEN-1:0] cfg;

  initial begin
    rst = 1'b1; cfg_en = 1'b0; cfg_din = 1'b0;
    in_v = 8'h00; ce = 2'b00; sr = 2'b00;

    // 1: reset, then no configuration -> everything stays 0.
    do_reset();
    in_v = 8'hFF; ce = 2'b11;
    for (int i = 0; i < 10; i++) step("unconfigured", 5'b00000);

    // 2: XOR-4 LUT in LE0, with a pause in the middle of the load.
    cfg  = {make_le(16'h0000, 1'b0, 1'b0, 2'b00, 1'b0),
            make_le(16'h6996, 1'b0, 1'b0, 2'b00, 1'b0)};
    in_v = 8'h07; ce = 2'b00;
    send_bits(cfg, 0, 20);
    cfg_din = 1'b1;
    for (int i = 0; i < 5; i++) step("pause", 5'b00000);
    send_bits(cfg, 20, 22);            // last step is the INIT cycle
    step("done_xor_0111", 5'b10001);
    in_v = 8'h03; step("xor_0011", 5'b10000);
    in_v = 8'h0F; step("xor_1111", 5'b10000);
    in_v = 8'h08; step("xor_1000", 5'b10001);

    // 3: LE1 as a toggle flop through the feedback path.
    cfg  = {make_le(16'h00FF, 1'b1, 1'b1, 2'b00, 1'b1),
            make_le(16'h6996, 1'b0, 1'b0, 2'b00, 1'b0)};
    in_v = 8'h00; ce = 2'b10; sr = 2'b00;
    load_full(cfg);
    step("toggle_init", 5'b10010);
    step("toggle_1",    5'b10000);
    step("toggle_2",    5'b10010);
    step("toggle_3",    5'b10000);
    ce = 2'b00;
    step("toggle_hold_a", 5'b10000);
    step("toggle_hold_b", 5'b10000);
    ce = 2'b10;
    step("toggle_resume", 5'b10010);

    // 4a: SRMODE=01 (set, CE-qualified), LUT all zero, INIT=0.
    cfg = {make_le(16'h0000, 1'b1, 1'b0, 2'b01, 1'b0), 21'd0};
    ce = 2'b00; sr = 2'b00;
    load_full(cfg);
    step("sr01_init", 5'b10000);
    sr = 2'b10;              step("sr01_ce0_hold", 5'b10000);
    ce = 2'b10;              step("sr01_set",      5'b10010);
    sr = 2'b00;              step("sr01_lut",      5'b10000);

    // 4b: SRMODE=11 (clear, ignores CE), LUT all one, INIT=1.
    cfg = {make_le(16'hFFFF, 1'b1, 1'b0, 2'b11, 1'b1), 21'd0};
    ce = 2'b00; sr = 2'b00;
    load_full(cfg);
    step("sr11_init", 5'b10010);
    sr = 2'b10;              step("sr11_ce0_clr", 5'b10000);
    sr = 2'b00;              step("sr11_hold",    5'b10000);
    ce = 2'b10;              step("sr11_lut",     5'b10010);

    // 4c: SRMODE=10 (clear, CE-qualified), LUT all one, INIT=1.
    cfg = {make_le(16'hFFFF, 1'b1, 1'b0, 2'b10, 1'b1), 21'd0};
    ce = 2'b00; sr = 2'b00;
    load_full(cfg);
    step("sr10_init", 5'b10010);
    sr = 2'b10;              step("sr10_ce0_hold", 5'b10010);
    ce = 2'b10;              step("sr10_clr",      5'b10000);
    sr = 2'b00;              step("sr10_lut",      5'b10010);

    // 4d: SRMODE=00 ignores SR, LUT all zero, INIT=1.
    cfg = {make_le(16'h0000, 1'b1, 1'b0, 2'b00, 1'b1), 21'd0};
    ce = 2'b00; sr = 2'b00;
    load_full(cfg);
    step("sr00_init", 5'b10010);
    ce = 2'b10; sr = 2'b10;  step("sr00_ignored", 5'b10000);

    // 5: reset in the middle of a load discards the partial load.
    cfg  = {21'd0, make_le(16'h6996, 1'b0, 1'b0, 2'b00, 1'b0)};
    in_v = 8'h07; ce = 2'b00; sr = 2'b00;
    do_reset();
    send_bits(cfg, 0, 30);
    do_reset();
    send_bits(cfg, 0, CFG_LEN - 1);
    step("reload_41_a", 5'b00000);
    step("reload_41_b", 5'b00000);
    send_bits(cfg, CFG_LEN - 1, 1);   // INIT cycle
    step("reload_done", 5'b10001);

    // 6: daisy-chain pass-through while active; configuration is frozen.
    cfg_en = 1'b1; cfg_din = 1'b1; step("pass_1", 5'b11101);
    cfg_din = 1'b0;                step("pass_0", 5'b11001);
    cfg_din = 1'b1;                step("pass_1b", 5'b11101);
    cfg_en = 1'b0; cfg_din = 1'b0; step("pass_off", 5'b10001);
    in_v = 8'h03;                  step("frozen_0011", 5'b10000);
    in_v = 8'h08;                  step("frozen_1000", 5'b10001);

    // Reset from the active state clears everything.
    do_reset();
    step("after_reset", 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
